// File: rtl/whack_judge_if.sv
// Judge bus: press/mole inputs from the edge detectors, score and status back out.
// master = stimulus side (mole generator / buttons), slave = whack_judge.
interface whack_judge_if #(
   parameter int N_HOLES = 9,
   parameter int SCORE_W = 8,
   parameter int MISS_W  = 4
);
   logic [N_HOLES-1:0] press;
   logic [N_HOLES-1:0] mole_mask;
   logic               start;
   logic               time_up;
   logic [SCORE_W-1:0] score;
   logic [MISS_W-1:0]  misses;
   logic [SCORE_W-1:0] streak;
   logic [N_HOLES-1:0] mole_clear;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               playing;
   logic               game_over;

   modport master (
      output press, mole_mask, start, time_up,
      input  score, misses, streak, mole_clear, hit_pulse, miss_pulse, playing, game_over
   );
   modport slave (
      input  press, mole_mask, start, time_up,
      output score, misses, streak, mole_clear, hit_pulse, miss_pulse, playing, game_over
   );
endinterface

// File: rtl/whack_judge.sv
// Whack-a-mole hit/miss judge and score keeper (IDLE/PLAY/OVER, all outputs registered).
// Optional combo scoring enabled by defining JUDGE_COMBO_EN.
module whack_judge #(
   parameter int N_HOLES  = 9,
   parameter int SCORE_W  = 8,
   parameter int MISS_W   = 4,
   parameter int MAX_MISS = 10,
   parameter int COMBO_TH = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   whack_judge_if.slave  bus
);
   localparam int CNT_W = $clog2(N_HOLES + 1);
   localparam int SW2   = SCORE_W + 2;
   localparam int MW2   = MISS_W + CNT_W;

   if (MAX_MISS < 1 || MAX_MISS > (2**MISS_W) - 1 || COMBO_TH > (2**SCORE_W) - 1)
      $error("whack_judge: MAX_MISS/COMBO_TH out of range");

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

   state_t             state, state_n;
   logic [SCORE_W-1:0] score_q, score_n;
   logic [MISS_W-1:0]  miss_q, miss_n;
   logic [N_HOLES-1:0] clr_q, clr_n;
   logic               hit_q, hit_n, mpl_q, mpl_n;
   logic [CNT_W-1:0]   hits, mcnt;
   logic [CNT_W:0]     pts;
   logic [SW2-1:0]     ssum;
   logic [MW2-1:0]     msum;
`ifdef JUDGE_COMBO_EN
   logic [SCORE_W-1:0] streak_q, streak_n;
   logic [SCORE_W:0]   tsum;
`endif

   function automatic logic [CNT_W-1:0] popcnt(input logic [N_HOLES-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_HOLES; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   always_comb begin
      state_n = state;
      score_n = score_q;
      miss_n  = miss_q;
      clr_n   = '0;
      hit_n   = 1'b0;
      mpl_n   = 1'b0;
      hits    = popcnt(bus.press & bus.mole_mask);
      mcnt    = popcnt(bus.press & ~bus.mole_mask);
      pts     = {1'b0, hits};
`ifdef JUDGE_COMBO_EN
      streak_n = streak_q;
      tsum     = {1'b0, streak_q} + (SCORE_W+1)'(hits);
      // Double points only on a clean cycle once the streak entering it has reached threshold
      if (streak_q >= SCORE_W'(COMBO_TH) && mcnt == '0) pts = {hits, 1'b0};
`endif
      ssum = SW2'(score_q) + SW2'(pts);
      msum = MW2'(miss_q) + MW2'(mcnt);

      case (state)
         IDLE, OVER: begin
            if (bus.start) begin
               score_n = '0;
               miss_n  = '0;
`ifdef JUDGE_COMBO_EN
               streak_n = '0;
`endif
               state_n = PLAY;
            end
         end
         PLAY: begin
            if (bus.start) begin
               // Restart: this cycle's presses are dropped
               score_n = '0;
               miss_n  = '0;
`ifdef JUDGE_COMBO_EN
               streak_n = '0;
`endif
            end else begin
               score_n = (ssum > SW2'((2**SCORE_W) - 1)) ? '1 : ssum[SCORE_W-1:0];
               miss_n  = (msum >= MW2'(MAX_MISS)) ? MISS_W'(MAX_MISS) : msum[MISS_W-1:0];
`ifdef JUDGE_COMBO_EN
               if (mcnt != '0)        streak_n = '0;
               else if (tsum[SCORE_W]) streak_n = '1;
               else                    streak_n = tsum[SCORE_W-1:0];
`endif
               clr_n = bus.press & bus.mole_mask;
               hit_n = (hits != '0);
               mpl_n = (mcnt != '0);
               if (msum >= MW2'(MAX_MISS) || bus.time_up) state_n = OVER;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         score_q <= '0;
         miss_q  <= '0;
         clr_q   <= '0;
         hit_q   <= 1'b0;
         mpl_q   <= 1'b0;
`ifdef JUDGE_COMBO_EN
         streak_q <= '0;
`endif
      end else begin
         state   <= state_n;
         score_q <= score_n;
         miss_q  <= miss_n;
         clr_q   <= clr_n;
         hit_q   <= hit_n;
         mpl_q   <= mpl_n;
`ifdef JUDGE_COMBO_EN
         streak_q <= streak_n;
`endif
      end
   end

   assign bus.score      = score_q;
   assign bus.misses     = miss_q;
   assign bus.mole_clear = clr_q;
   assign bus.hit_pulse  = hit_q;
   assign bus.miss_pulse = mpl_q;
   assign bus.playing    = (state == PLAY);
   assign bus.game_over  = (state == OVER);
`ifdef JUDGE_COMBO_EN
   assign bus.streak     = streak_q;
`else
   assign bus.streak     = '0;
`endif
endmodule

// File: tb/tb_whack_judge.sv
// Directed + random bench for whack_judge against a game-rules reference model.
module tb_whack_judge;
   localparam int N = 9, SW = 8, MW = 4, MAXM = 10, CTH = 3;
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   whack_judge_if #(.N_HOLES(N), .SCORE_W(SW), .MISS_W(MW)) bus ();
   whack_judge #(.N_HOLES(N), .SCORE_W(SW), .MISS_W(MW), .MAX_MISS(MAXM), .COMBO_TH(CTH))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   // Reference model: game rules as plain integers
   bit         m_play, m_over, m_hp, m_mp;
   int         m_score, m_miss, m_streak;
   logic [N-1:0] m_clr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".score"},  32'(bus.score),      32'(m_score));
      chk({tag, ".misses"}, 32'(bus.misses),     32'(m_miss));
      chk({tag, ".streak"}, 32'(bus.streak),     32'(m_streak));
      chk({tag, ".clear"},  32'(bus.mole_clear), 32'(m_clr));
      chk({tag, ".hitp"},   32'(bus.hit_pulse),  32'(m_hp));
      chk({tag, ".missp"},  32'(bus.miss_pulse), 32'(m_mp));
      chk({tag, ".play"},   32'(bus.playing),    32'(m_play));
      chk({tag, ".over"},   32'(bus.game_over),  32'(m_over));
   endtask

   task automatic model_reset();
      m_play = 0; m_over = 0; m_hp = 0; m_mp = 0;
      m_score = 0; m_miss = 0; m_streak = 0; m_clr = '0;
   endtask

   task automatic model_update(input logic [N-1:0] p, input logic [N-1:0] m, input bit s, input bit tu);
      int h, mc, pts;
      m_clr = '0; m_hp = 0; m_mp = 0;
      if (s) begin
         m_score = 0; m_miss = 0; m_streak = 0;
         m_play = 1; m_over = 0;
      end else if (m_play) begin
         h   = $countones(p & m);
         mc  = $countones(p & ~m);
         pts = h;
`ifdef JUDGE_COMBO_EN
         if (m_streak >= CTH && mc == 0) pts = 2 * h;
         m_streak = (mc != 0) ? 0 : ((m_streak + h > SMAX) ? SMAX : m_streak + h);
`endif
         m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
         m_miss  = (m_miss + mc > MAXM) ? MAXM : m_miss + mc;
         m_clr = p & m;
         m_hp  = (h != 0);
         m_mp  = (mc != 0);
         if (m_miss >= MAXM || tu) begin
            m_play = 0; m_over = 1;
         end
      end
   endtask

   task automatic step(input string tag, input logic [N-1:0] p, input logic [N-1:0] m,
                       input bit s, input bit tu);
      bus.press = p; bus.mole_mask = m; bus.start = s; bus.time_up = tu;
      @(posedge clk);
      model_update(p, m, s, tu);
      #1;
      bus.press = '0; bus.mole_mask = '0; bus.start = 1'b0; bus.time_up = 1'b0;
      check_all(tag);
   endtask

   initial begin
      bus.press = '0; bus.mole_mask = '0; bus.start = 1'b0; bus.time_up = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk) rst_n = 1'b1;

      step("idle_press", 9'h001, 9'h001, 0, 0);
      step("start", '0, '0, 1, 0);
      step("hit1", 9'h001, 9'h001, 0, 0);
      chk("hit1.lit_score", 32'(bus.score), 32'd1);
      chk("hit1.lit_clear", 32'(bus.mole_clear), 32'h001);
      step("quiet", '0, '0, 0, 0);
      step("hitmiss", 9'h006, 9'h002, 0, 0);
      chk("hitmiss.lit_clear", 32'(bus.mole_clear), 32'h002);

      // ten single misses end the game
      step("restart", '0, '0, 1, 0);
      for (int i = 0; i < 10; i++) step("miss10", 9'h010, 9'h000, 0, 0);
      chk("miss10.lit_misses", 32'(bus.misses), 32'd10);
      chk("miss10.lit_over", 32'(bus.game_over), 32'd1);
      step("over_press", 9'h003, 9'h003, 0, 0);
      step("over_start", '0, '0, 1, 0);

      // score saturation
      for (int i = 0; i < 29; i++) step("fill", 9'h1FF, 9'h1FF, 0, 0);
      chk("fill.lit_score", 32'(bus.score), 32'd255);
      step("sat_score", 9'h003, 9'h003, 0, 0);
      chk("sat_score.lit", 32'(bus.score), 32'd255);

      // miss saturation with a multi-miss
      for (int i = 0; i < 8; i++) step("miss8", 9'h100, 9'h000, 0, 0);
      step("multimiss", 9'h1FF, 9'h000, 0, 0);
      chk("multimiss.lit_misses", 32'(bus.misses), 32'd10);

      // combo sequence (plain scoring when combo disabled)
      step("combo_start", '0, '0, 1, 0);
      for (int i = 0; i < 3; i++) step("combo_hit", 9'h020, 9'h020, 0, 0);
      step("combo_hit4", 9'h020, 9'h020, 0, 0);
`ifdef JUDGE_COMBO_EN
      chk("combo4.lit_score", 32'(bus.score), 32'd5);
      chk("combo4.lit_streak", 32'(bus.streak), 32'd4);
`endif
      step("combo_miss", 9'h040, 9'h020, 0, 0);
      step("combo_after", 9'h020, 9'h020, 0, 0);
`ifdef JUDGE_COMBO_EN
      chk("combo_after.lit_score", 32'(bus.score), 32'd6);
`endif
      step("time_up_hit", 9'h001, 9'h001, 0, 1);

      // asynchronous reset mid-play
      step("rst_start", '0, '0, 1, 0);
      step("seven", 9'h07F, 9'h07F, 0, 0);
      chk("seven.lit_score", 32'(bus.score), 32'd7);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      step("post_rst", '0, '0, 0, 0);
      step("start_tu", 9'h001, 9'h001, 1, 1);

      // random play
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] p, m;
         p = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         m = N'($urandom);
         if ($urandom_range(0, 3) == 0) p = p & m;
         step("rand", p, m, ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
